hex_overlay: RTL and testbench

HEX_OVERLAY -- requirements
Module: hex_overlay

---
 rtl/font_pkg.sv | 10 +
 rtl/hex_overlay_shadow.sv | 36 +++
 rtl/hex_overlay.sv | 111 +++++++++++
 tb/tb_hex_overlay.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/font_pkg.sv
// rtl/font_pkg.sv - glyph geometry and nibble type shared by the glyph engine and the hex overlay
package font_pkg;

    localparam int CHAR_W = 6;
    localparam int CHAR_H = 8;
    localparam int GLYPHS = 16;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/hex_overlay_shadow.sv
// rtl/hex_overlay_shadow.sv - pending/shadow double buffer updated on the vsync rising edge
module hex_overlay_shadow (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic [31:0] value,
    input  logic        value_valid,
    output logic [31:0] shadow,
    output logic        frame_tick
);

    logic [31:0] pending;
    logic        vsync_q;

    // a held-high vsync yields one boundary because vsync_q follows it
    assign frame_tick = vsync && !vsync_q;

    // latest strobe lands in pending; shadow only moves on a frame boundary,
    // taking the coincident strobe directly so it is not lost for a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            shadow  <= '0;
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (value_valid) begin
                pending <= value;
            end
            if (frame_tick) begin
                shadow <= value_valid ? value : pending;
            end
        end
    end

endmodule

// File: rtl/hex_overlay.sv
// rtl/hex_overlay.sv - hex value overlay on the character grid (optional blink: HEX_OVERLAY_BLINK_EN)
module hex_overlay
    import font_pkg::*;
#(
    parameter int ROW  = 2,
    parameter int COL  = 4,
    parameter int NDIG = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              blank,
    input  logic              vsync,
    input  logic [6:0]        char_x,
    input  logic [6:0]        char_y,
    input  logic [GLYPHS-1:0] char_data,
    input  logic [31:0]       value,
    input  logic              value_valid,
    input  logic              blink,
    output logic              pix,
    output logic              in_win
);

    // 8-bit bounds so COL+NDIG-1 past column 127 cannot wrap
    localparam logic [7:0] COL_LO = 8'(COL);
    localparam logic [7:0] COL_HI = 8'(COL + NDIG - 1);
    localparam logic [2:0] MS_IDX = 3'(NDIG - 1);

    if (NDIG < 1 || NDIG > 8 || GLYPHS != 16 || CHAR_W * CHAR_H == 0) begin : g_bad_cfg
        $error("hex_overlay: unsupported digit count or font geometry");
    end

    logic [31:0] shadow;
    logic        frame_tick;

    hex_overlay_shadow u_shadow (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .value       (value),
        .value_valid (value_valid),
        .shadow      (shadow),
        .frame_tick  (frame_tick)
    );

    logic [6:0] x_q;
    logic [6:0] y_q;
    logic       blank_q;

    // delay position and blank by one so they line up with char_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            blank_q <= 1'b0;
        end else begin
            x_q     <= char_x;
            y_q     <= char_y;
            blank_q <= blank;
        end
    end

    logic [7:0] x8;
    logic [2:0] digit;
    logic [2:0] nib_idx;
    nibble_t    nibble;
    logic       win_d;
    logic       pix_d;
    logic       dark;

    // digit 0 is leftmost and shows the most significant displayed nibble;
    // only the low 3 bits of the offset matter inside the window
    always_comb begin
        x8      = {1'b0, x_q};
        win_d   = (y_q == 7'(ROW)) && (x8 >= COL_LO) && (x8 <= COL_HI) && !blank_q;
        digit   = x_q[2:0] - COL_LO[2:0];
        nib_idx = MS_IDX - digit;
        nibble  = nibble_t'(shadow >> {nib_idx, 2'b00});
        pix_d   = win_d && char_data[nibble];
    end

`ifdef HEX_OVERLAY_BLINK_EN
    logic [5:0] frame_cnt;

    // free-running frame count; bit 5 gives 32 lit frames then 32 dark
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    assign dark = blink && frame_cnt[5];
`else
    logic unused_blink_cfg;
    assign unused_blink_cfg = blink ^ frame_tick;
    assign dark = 1'b0;
`endif

    // register the overlay outputs, blanked during the dark half of a blink
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix    <= 1'b0;
            in_win <= 1'b0;
        end else begin
            pix    <= pix_d && !dark;
            in_win <= win_d && !dark;
        end
    end

endmodule

// File: tb/tb_hex_overlay.sv
// tb/tb_hex_overlay.sv - self-checking bench for hex_overlay against a frame-level model
module tb_hex_overlay;

    localparam int ROW  = 2;
    localparam int COL  = 4;
    localparam int NDIG = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blank = 1'b0;
    logic        vsync = 1'b0;
    logic [6:0]  char_x = '0;
    logic [6:0]  char_y = '0;
    logic [15:0] char_data = '0;
    logic [31:0] value = '0;
    logic        value_valid = 1'b0;
    logic        blink = 1'b0;
    logic        pix;
    logic        in_win;

    int errors = 0;
    int checks = 0;

    hex_overlay #(.ROW(ROW), .COL(COL), .NDIG(NDIG)) u_dut (
        .clk         (clk),
        .reset       (rst_n),
        .blank       (blank),
        .vsync       (vsync),
        .char_x      (char_x),
        .char_y      (char_y),
        .char_data   (char_data),
        .value       (value),
        .value_valid (value_valid),
        .blink       (blink),
        .pix         (pix),
        .in_win      (in_win)
    );

    always #5 clk = ~clk;

    // frame-level model: displayed word changes only at a vsync rise, the
    // digit under the aligned position picks a glyph lane of char_data
    logic [31:0] m_pend = '0;
    logic [31:0] m_shadow = '0;
    logic        m_vs = 1'b0;
    int          m_px = 0;
    int          m_py = 0;
    logic        m_pb = 1'b0;
    int          m_frames = 0;
    logic        exp_pix = 1'b0;
    logic        exp_win = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_shadow = '0; m_vs = 1'b0;
            m_px = 0; m_py = 0; m_pb = 1'b0; m_frames = 0;
            exp_pix = 1'b0; exp_win = 1'b0;
        end else begin
            logic w;
            logic dk;
            int   dig;
            w = (m_py == ROW) && (m_px >= COL) && (m_px <= COL + NDIG - 1) && !m_pb;
            dig = int'((m_shadow >> (4 * (NDIG - 1 - (m_px - COL)))) & 32'hF);
`ifdef HEX_OVERLAY_BLINK_EN
            dk = blink && ((m_frames % 64) >= 32);
`else
            dk = 1'b0;
`endif
            exp_win = w && !dk;
            exp_pix = w && !dk && char_data[dig[3:0]];
            m_px = int'(char_x); m_py = int'(char_y); m_pb = blank;
            if (value_valid) m_pend = value;
            if (vsync && !m_vs) begin
                m_shadow = m_pend;
                m_frames = m_frames + 1;
            end
            m_vs = vsync;
        end
    end

    // every cycle the outputs must match the model
    always @(negedge clk) begin
        checks++;
        if (pix !== exp_pix || in_win !== exp_win) begin
            errors++;
            $display("FAIL cycle_model t=%0t pix=%b in_win=%b required pix=%b in_win=%b",
                     $time, pix, in_win, exp_pix, exp_win);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // position presented, then its glyph lanes one cycle later; returns the outputs
    task automatic probe(input int x, input int y, input logic b, input logic [15:0] d,
                         output logic p, output logic w);
        char_x = 7'(x); char_y = 7'(y); blank = b;
        @(posedge clk); #1;
        char_data = d; char_x = '0; char_y = '0; blank = 1'b0;
        @(posedge clk); @(negedge clk);
        p = pix; w = in_win;
        #1;
    endtask

    int nfr = 0;

    task automatic vs_pulse();
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        nfr++;
        @(posedge clk); #1;
    endtask

    logic [3:0] lit_nib [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};

    initial begin
        logic p, w;
        logic [15:0] lane;

        repeat (3) @(posedge clk);
        #1;
        check("reset_pix", 32'(pix), 32'd0);
        check("reset_in_win", 32'(in_win), 32'd0);
        check("reset_shadow", u_dut.u_shadow.shadow, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // load 1234ABCD and show it
        value = 32'h1234ABCD; value_valid = 1'b1;
        @(posedge clk); #1;
        value_valid = 1'b0;
        vs_pulse();
        for (int d = 0; d < 8; d++) begin
            lane = 16'h0001 << lit_nib[d];
            probe(COL + d, ROW, 1'b0, lane, p, w);
            check($sformatf("digit%0d_lit", d), 32'(p), 32'd1);
            check($sformatf("digit%0d_win", d), 32'(w), 32'd1);
            probe(COL + d, ROW, 1'b0, ~lane, p, w);
            check($sformatf("digit%0d_other_lanes", d), 32'(p), 32'd0);
        end

        // mid-frame strobe must not tear the current frame
        value = 32'hFFFF0000; value_valid = 1'b1;
        @(posedge clk); #1;
        value_valid = 1'b0;
        check("midframe_shadow_hold", u_dut.u_shadow.shadow, 32'h1234ABCD);
        probe(COL, ROW, 1'b0, 16'h0002, p, w);
        check("midframe_old_digit", 32'(p), 32'd1);
        vs_pulse();
        check("next_frame_shadow", u_dut.u_shadow.shadow, 32'hFFFF0000);
        probe(COL, ROW, 1'b0, 16'h8000, p, w);
        check("next_frame_digit_F", 32'(p), 32'd1);
        probe(COL + 7, ROW, 1'b0, 16'h0001, p, w);
        check("next_frame_digit_0", 32'(p), 32'd1);

        // strobe on the boundary cycle goes straight to shadow
        vsync = 1'b1; value = 32'h00000005; value_valid = 1'b1;
        @(posedge clk); #1;
        value_valid = 1'b0;
        nfr++;
        check("coincident_shadow", u_dut.u_shadow.shadow, 32'h00000005);
        // vsync still high: a further strobe waits in pending
        value = 32'h00000077; value_valid = 1'b1;
        @(posedge clk); #1;
        value_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held_vsync_shadow", u_dut.u_shadow.shadow, 32'h00000005);
        vsync = 1'b0;
        @(posedge clk); #1;

        // outside the window nothing lights
        probe(COL, 3, 1'b0, 16'hFFFF, p, w);
        check("row3_pix", 32'(p), 32'd0);
        check("row3_win", 32'(w), 32'd0);
        probe(3, ROW, 1'b0, 16'hFFFF, p, w);
        check("col3_pix", 32'(p), 32'd0);
        check("col3_win", 32'(w), 32'd0);
        probe(12, ROW, 1'b0, 16'hFFFF, p, w);
        check("col12_pix", 32'(p), 32'd0);
        check("col12_win", 32'(w), 32'd0);
        probe(COL, ROW, 1'b1, 16'hFFFF, p, w);
        check("blank_pix", 32'(p), 32'd0);
        check("blank_win", 32'(w), 32'd0);
        probe(COL + 7, ROW, 1'b0, 16'h0020, p, w);
        check("digit5_shown", 32'(p), 32'd1);

        // reset mid-line clears outputs without a clock edge
        char_x = 7'(COL + 7); char_y = 7'(ROW);
        @(posedge clk); #1;
        char_data = 16'hFFFF;
        @(posedge clk); #2;
        check("preset_pix", 32'(pix), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_pix", 32'(pix), 32'd0);
        check("async_reset_win", 32'(in_win), 32'd0);
        check("async_reset_shadow", u_dut.u_shadow.shadow, 32'd0);
        char_x = '0; char_y = '0; char_data = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nfr = 0;
        probe(COL + 7, ROW, 1'b0, 16'h0001, p, w);
        check("after_reset_zero_lit", 32'(p), 32'd1);
        probe(COL + 7, ROW, 1'b0, 16'hFFFE, p, w);
        check("after_reset_zero_only", 32'(p), 32'd0);

        // blink over more than one 64-frame period
        blink = 1'b1;
        for (int f = 0; f < 70; f++) begin
            logic exp_lit;
            vs_pulse();
`ifdef HEX_OVERLAY_BLINK_EN
            exp_lit = (nfr % 64) < 32;
`else
            exp_lit = 1'b1;
`endif
            probe(COL, ROW, 1'b0, 16'hFFFF, p, w);
            check($sformatf("blink_frame%0d", nfr), 32'(p), 32'(exp_lit));
        end
        blink = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
